// File: rtl/poly_alu_pkg.sv
// Shared types and constants for the polynomial ALU sequencer: FSM states,
// opcodes, the opcode-to-ALU-mode table and the default sizing.
package poly_alu_pkg;

   localparam int N_COEF_DEF  = 256;
   localparam int ALU_LAT_DEF = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      OP_ADD    = 3'd0,
      OP_SUB    = 3'd1,
      OP_MUL    = 3'd2,
      OP_MULADD = 3'd3,
      OP_MULSUB = 3'd4
   } opcode_e;

   // Indexed by opcode value; entries 5..7 do not exist (illegal opcodes).
   localparam logic [9:0] MODE_TABLE [5] = '{
      10'h041,
      10'h043,
      10'h108,
      10'h149,
      10'h14B
   };

endpackage

// File: rtl/poly_alu_opdec.sv
// Combinational opcode decoder: maps a 3-bit command opcode to its 10-bit
// ALU mode word and flags whether the opcode is legal.
module poly_alu_opdec
   import poly_alu_pkg::*;
(
   input  logic [2:0] op_i,
   output logic [9:0] mode_o,
   output logic       legal_o
);

   always_comb begin
      mode_o  = '0;
      legal_o = 1'b1;
      case (op_i)
         OP_ADD:    mode_o = MODE_TABLE[0];
         OP_SUB:    mode_o = MODE_TABLE[1];
         OP_MUL:    mode_o = MODE_TABLE[2];
         OP_MULADD: mode_o = MODE_TABLE[3];
         OP_MULSUB: mode_o = MODE_TABLE[4];
         default:   legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/poly_alu_seq.sv
// Polynomial ALU sequencer: streams N_COEF operand reads into a fixed-latency
// ALU and writes each returned result back in order, one command at a time.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// ISSUE | one operand read per cycle, addresses 0..N_COEF-1
// DRAIN | all reads issued, waiting for the remaining ALU results
// DONE  | last result written, done pulse for one cycle
module poly_alu_seq
   import poly_alu_pkg::*;
#(
   parameter int N_COEF  = N_COEF_DEF,
   parameter int ALU_LAT = ALU_LAT_DEF,
   parameter int ADDR_W  = 8
) (
   input  logic              poly_clk,
   input  logic              poly_rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic              alu_enable,
   output logic [9:0]        alu_mode,
   input  logic              alu_valid,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(N_COEF - 1);
   localparam logic [ADDR_W:0] CNT_END  = (ADDR_W+1)'(N_COEF);

   if (ALU_LAT < 1) begin : g_lat_chk
      $error("poly_alu_seq: ALU_LAT must be at least 1");
   end
   if (N_COEF < 1 || N_COEF > (1 << ADDR_W)) begin : g_ncoef_chk
      $error("poly_alu_seq: N_COEF must fit in ADDR_W address bits");
   end

   state_e          state_q, state_d;
   logic [ADDR_W:0] rd_cnt_q, rd_cnt_d;
   logic [ADDR_W:0] wr_cnt_q, wr_cnt_d;
   logic [9:0]      mode_q, mode_d;
   logic            alu_en_q;
   logic            err_q, err_d;
   logic [9:0]      dec_mode;
   logic            dec_legal;
   logic            accept;
   logic            wr_fire;

   poly_alu_opdec u_opdec (
      .op_i    (cmd_op),
      .mode_o  (dec_mode),
      .legal_o (dec_legal)
   );

   // cmd_ready is gated by reset so it reads 0 while reset is held.
   assign cmd_ready   = (state_q == IDLE) && !poly_rst;
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign accept      = cmd_valid && cmd_ready;
   assign wr_fire     = alu_valid && busy && (wr_cnt_q < CNT_END);
   assign mem_wr_en   = wr_fire;
   assign mem_wr_addr = wr_cnt_q[ADDR_W-1:0];
   assign mem_rd_addr = rd_cnt_q[ADDR_W-1:0];
   assign alu_enable  = alu_en_q;
   assign alu_mode    = mode_q;
   assign err         = err_q;

   always_comb begin
      state_d   = state_q;
      rd_cnt_d  = rd_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      mode_d    = mode_q;
      mem_rd_en = 1'b0;
      // Any alu_valid that cannot be written is spurious.
      err_d     = alu_valid && !wr_fire;

      if (wr_fire) begin
         wr_cnt_d = wr_cnt_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (dec_legal) begin
                  mode_d   = dec_mode;
                  rd_cnt_d = '0;
                  wr_cnt_d = '0;
                  state_d  = ISSUE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ISSUE: begin
            mem_rd_en = 1'b1;
            rd_cnt_d  = rd_cnt_q + 1'b1;
            if (rd_cnt_q == CNT_LAST) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (wr_fire && wr_cnt_q == CNT_LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge poly_clk or posedge poly_rst) begin
      if (poly_rst) begin
         state_q  <= IDLE;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         mode_q   <= '0;
         alu_en_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
         mode_q   <= mode_d;
         alu_en_q <= mem_rd_en;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_poly_alu_seq.sv
// Bench for poly_alu_seq: a default-size instance and an N_COEF=4/ALU_LAT=2
// instance, each fed by a fixed-latency ALU model with spurious-valid injection.
module tb_poly_alu_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // big instance (defaults) signals
   logic       b_cmd_valid, b_cmd_ready, b_rd_en, b_wr_en, b_alu_en, b_alu_valid;
   logic       b_busy, b_done, b_err, b_inj;
   logic [2:0] b_cmd_op;
   logic [7:0] b_rd_addr, b_wr_addr;
   logic [9:0] b_mode;
   logic [4:0] b_sh;
   // small instance (N_COEF=4, ALU_LAT=2) signals
   logic       s_cmd_valid, s_cmd_ready, s_rd_en, s_wr_en, s_alu_en, s_alu_valid;
   logic       s_busy, s_done, s_err, s_inj;
   logic [2:0] s_cmd_op;
   logic [7:0] s_rd_addr, s_wr_addr;
   logic [9:0] s_mode;
   logic [1:0] s_sh;

   poly_alu_seq #(.N_COEF(256), .ALU_LAT(5), .ADDR_W(8)) u_big (
      .poly_clk(clk), .poly_rst(rst),
      .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_op(b_cmd_op),
      .mem_rd_en(b_rd_en), .mem_rd_addr(b_rd_addr),
      .mem_wr_en(b_wr_en), .mem_wr_addr(b_wr_addr),
      .alu_enable(b_alu_en), .alu_mode(b_mode), .alu_valid(b_alu_valid),
      .busy(b_busy), .done(b_done), .err(b_err)
   );

   poly_alu_seq #(.N_COEF(4), .ALU_LAT(2), .ADDR_W(8)) u_small (
      .poly_clk(clk), .poly_rst(rst),
      .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_op(s_cmd_op),
      .mem_rd_en(s_rd_en), .mem_rd_addr(s_rd_addr),
      .mem_wr_en(s_wr_en), .mem_wr_addr(s_wr_addr),
      .alu_enable(s_alu_en), .alu_mode(s_mode), .alu_valid(s_alu_valid),
      .busy(s_busy), .done(s_done), .err(s_err)
   );

   // ALU models: valid follows enable by exactly ALU_LAT cycles; reset flushes them
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         b_sh <= '0;
         s_sh <= '0;
      end else begin
         b_sh <= {b_sh[3:0], b_alu_en};
         s_sh <= {s_sh[0], s_alu_en};
      end
   end
   assign b_alu_valid = b_sh[4] | b_inj;
   assign s_alu_valid = s_sh[1] | s_inj;

   // monitor mux: sel=0 watches the big instance, sel=1 the small one
   logic       sel = 1'b0;
   logic       m_rd_en, m_wr_en, m_busy, m_done, m_err, m_ready;
   logic [7:0] m_rd_addr, m_wr_addr;
   logic [9:0] m_mode;
   assign m_rd_en   = sel ? s_rd_en     : b_rd_en;
   assign m_wr_en   = sel ? s_wr_en     : b_wr_en;
   assign m_busy    = sel ? s_busy      : b_busy;
   assign m_done    = sel ? s_done      : b_done;
   assign m_err     = sel ? s_err       : b_err;
   assign m_ready   = sel ? s_cmd_ready : b_cmd_ready;
   assign m_rd_addr = sel ? s_rd_addr   : b_rd_addr;
   assign m_wr_addr = sel ? s_wr_addr   : b_wr_addr;
   assign m_mode    = sel ? s_mode      : b_mode;

   int r_reads, r_writes, r_first_wr, r_last_wr, r_done_cyc, r_done_cnt;
   int r_errs, r_ready_cyc, r_bad, r_busy_cnt;
   bit r_timeout, r_aborted;
   int sb[$];

   task automatic check(input string name, input longint got, input longint exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic drive_cmd(input logic v, input logic [2:0] op);
      if (sel) begin
         s_cmd_valid = v;
         s_cmd_op    = op;
      end else begin
         b_cmd_valid = v;
         b_cmd_op    = op;
      end
   endtask

   // Issue one command on the selected instance and observe it cycle by cycle;
   // cycle 0 is the cycle right after the accept edge.
   task automatic run_cmd(input logic [2:0] op, input bit hold, input bit skip_drive,
                          input int abort_addr, input int max_cyc);
      int cyc;
      int rd_exp;
      int exp_addr;
      r_reads = 0; r_writes = 0; r_first_wr = -1; r_last_wr = -1;
      r_done_cyc = -1; r_done_cnt = 0; r_errs = 0; r_ready_cyc = -1;
      r_bad = 0; r_busy_cnt = 0; r_aborted = 0; r_timeout = 0;
      sb.delete();
      rd_exp = 0;
      if (!skip_drive) begin
         @(negedge clk);
         drive_cmd(1'b1, op);
      end
      @(posedge clk);
      cyc = 0;
      while (cyc < max_cyc) begin
         @(negedge clk);
         if (!hold) drive_cmd(1'b0, op);
         if (m_rd_en) begin
            if (int'(m_rd_addr) != rd_exp || cyc != rd_exp) r_bad++;
            sb.push_back(int'(m_rd_addr));
            rd_exp++;
            r_reads++;
            if (abort_addr >= 0 && int'(m_rd_addr) == abort_addr) begin
               r_aborted = 1;
               break;
            end
         end
         if (m_wr_en) begin
            if (sb.size() == 0) r_bad++;
            else begin
               exp_addr = sb.pop_front();
               if (int'(m_wr_addr) != exp_addr) r_bad++;
            end
            if (r_first_wr < 0) r_first_wr = cyc;
            r_last_wr = cyc;
            r_writes++;
         end
         if (m_err)  r_errs++;
         if (m_busy) r_busy_cnt++;
         if (m_done) begin
            r_done_cnt++;
            if (r_done_cyc < 0) r_done_cyc = cyc;
         end
         if (m_ready && r_ready_cyc < 0) r_ready_cyc = cyc;
         if (r_done_cyc >= 0 && cyc == r_done_cyc + 1) break;
         cyc++;
      end
      r_timeout = (cyc >= max_cyc);
   endtask

   typedef struct {
      logic [2:0] op;
      bit         legal;
      logic [9:0] mode;
   } vec_t;

   vec_t vecs[8];

   initial begin
      logic [9:0] prev_mode;
      b_cmd_valid = 0; b_cmd_op = 0; b_inj = 0;
      s_cmd_valid = 0; s_cmd_op = 0; s_inj = 0;

      vecs[0] = '{3'd0, 1'b1, 10'h041};
      vecs[1] = '{3'd5, 1'b0, 10'h000};
      vecs[2] = '{3'd1, 1'b1, 10'h043};
      vecs[3] = '{3'd2, 1'b1, 10'h108};
      vecs[4] = '{3'd6, 1'b0, 10'h000};
      vecs[5] = '{3'd3, 1'b1, 10'h149};
      vecs[6] = '{3'd4, 1'b1, 10'h14B};
      vecs[7] = '{3'd7, 1'b0, 10'h000};

      // reset state, while reset is held and right after release
      repeat (3) @(negedge clk);
      check("rst_held_outputs",
            {b_cmd_ready, b_busy, b_done, b_err, b_rd_en, b_wr_en, b_alu_en, b_rd_addr, b_wr_addr, b_mode}, 0);
      rst = 1'b0;
      #1;
      check("rst_release_ready", b_cmd_ready, 1);
      check("rst_release_busy", b_busy, 0);

      // full ADD at default size
      sel = 1'b0;
      run_cmd(3'd0, 0, 0, -1, 600);
      check("add_timeout", r_timeout, 0);
      check("add_reads", r_reads, 256);
      check("add_writes", r_writes, 256);
      check("add_first_wr_cyc", r_first_wr, 6);
      check("add_last_wr_cyc", r_last_wr, 261);
      check("add_done_cyc", r_done_cyc, 262);
      check("add_done_pulses", r_done_cnt, 1);
      check("add_err", r_errs, 0);
      check("add_addr_seq", r_bad, 0);
      check("add_mode", b_mode, 10'h041);
      check("add_ready_after_done", r_ready_cyc, 263);

      // illegal opcode
      run_cmd(3'd6, 0, 0, -1, 8);
      check("ill_err_pulses", r_errs, 1);
      check("ill_busy", r_busy_cnt, 0);
      check("ill_mem", r_reads + r_writes, 0);
      check("ill_mode_kept", b_mode, 10'h041);

      // spurious alu_valid while idle
      @(negedge clk);
      b_inj = 1'b1;
      #1;
      check("spur_no_write", b_wr_en, 0);
      @(negedge clk);
      b_inj = 1'b0;
      check("spur_err", b_err, 1);
      @(negedge clk);
      check("spur_err_single", b_err, 0);
      check("spur_busy", b_busy, 0);

      // MUL with cmd_valid held: next accept only right after done
      run_cmd(3'd2, 1, 0, -1, 600);
      check("hold_done_cyc", r_done_cyc, 262);
      check("hold_ready_cyc", r_ready_cyc, 263);
      check("hold_mode", b_mode, 10'h108);
      run_cmd(3'd2, 0, 1, -1, 600);
      check("hold2_reads", r_reads, 256);
      check("hold2_done_cyc", r_done_cyc, 262);
      check("hold2_bad", r_bad + r_errs, 0);

      // reset in the middle of an ADD
      run_cmd(3'd0, 0, 0, 100, 600);
      check("abort_reached", r_aborted, 1);
      rst = 1'b1;
      #1;
      check("abort_outputs",
            {b_cmd_ready, b_busy, b_done, b_err, b_rd_en, b_wr_en, b_alu_en, b_rd_addr, b_wr_addr, b_mode}, 0);
      @(negedge clk);
      check("abort_no_done", b_done, 0);
      rst = 1'b0;
      #1;
      check("abort_ready", b_cmd_ready, 1);
      run_cmd(3'd0, 0, 0, -1, 600);
      check("rerun_reads", r_reads, 256);
      check("rerun_writes", r_writes, 256);
      check("rerun_done_cyc", r_done_cyc, 262);
      check("rerun_bad", r_bad + r_errs, 0);

      // table over all opcodes on the small instance
      sel = 1'b1;
      prev_mode = s_mode;
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].legal) begin
            run_cmd(vecs[i].op, 0, 0, -1, 40);
            check($sformatf("tbl%0d_done_cyc", i), r_done_cyc, 7);
            check($sformatf("tbl%0d_first_wr", i), r_first_wr, 3);
            check($sformatf("tbl%0d_last_wr", i), r_last_wr, 6);
            check($sformatf("tbl%0d_writes", i), r_writes, 4);
            check($sformatf("tbl%0d_err_bad", i), r_errs + r_bad, 0);
            check($sformatf("tbl%0d_mode", i), s_mode, vecs[i].mode);
            prev_mode = vecs[i].mode;
         end else begin
            run_cmd(vecs[i].op, 0, 0, -1, 6);
            check($sformatf("tbl%0d_err", i), r_errs, 1);
            check($sformatf("tbl%0d_busy", i), r_busy_cnt, 0);
            check($sformatf("tbl%0d_mode_kept", i), s_mode, prev_mode);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
